// File: rtl/keypad_operand_capture_if.sv
// Keypad-to-multiplier operand bus: key strobe/code in, operand pair and entry display out.
// The slave modport is the operand capture block; master is whoever drives keys and acks.
interface keypad_operand_capture_if #(
  parameter int unsigned OP_W = 8
) ();
  logic            data_available;
  logic [3:0]      dato_i;
  logic            result_ack;
  logic [OP_W-1:0] operand_a;
  logic [OP_W-1:0] operand_b;
  logic            operands_valid;
  logic [OP_W-1:0] entry_value;
  logic [1:0]      entry_sel;

  modport master (
    output data_available,
    output dato_i,
    output result_ack,
    input  operand_a,
    input  operand_b,
    input  operands_valid,
    input  entry_value,
    input  entry_sel
  );

  modport slave (
    input  data_available,
    input  dato_i,
    input  result_ack,
    output operand_a,
    output operand_b,
    output operands_valid,
    output entry_value,
    output entry_sel
  );
endinterface

// File: rtl/keypad_operand_capture.sv
// Assembles decimal key presses into two binary operands and holds them for the multiplier
// until acknowledged. One key acceptance per rising edge of data_available.
module keypad_operand_capture #(
  parameter int unsigned MAX_DIGITS = 2,
  parameter int unsigned OP_W       = 8,
  parameter logic [3:0]  KEY_ENTER  = 4'hA,
  parameter logic [3:0]  KEY_CLEAR  = 4'hC
) (
  input logic                     clk,
  input logic                     rst,
  keypad_operand_capture_if.slave kp
);

  localparam int unsigned CntW = (MAX_DIGITS + 1 > 2) ? $clog2(MAX_DIGITS + 1) : 1;
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_DIGITS);

  typedef enum logic [1:0] {
    StEnterA = 2'd0,
    StEnterB = 2'd1,
    StHold   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            da_q;
  logic [OP_W-1:0] acc_q, acc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [OP_W-1:0] op_a_q, op_a_d;
  logic [OP_W-1:0] op_b_q, op_b_d;
  logic            valid_q, valid_d;

  logic            key_accept;
  logic            is_digit;
  logic [OP_W-1:0] acc_shift;

  assign key_accept = kp.data_available & ~da_q;
  assign is_digit   = (kp.dato_i <= 4'd9);
  // acc*10 + digit; modulo-2^OP_W matches truncation of the wider sum.
  assign acc_shift  = (acc_q << 3) + (acc_q << 1) + OP_W'(kp.dato_i);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    valid_d = valid_q;

    if (key_accept && (kp.dato_i == KEY_CLEAR)) begin
      // Clear beats a coincident ack in HOLD.
      state_d = StEnterA;
      acc_d   = '0;
      cnt_d   = '0;
      op_a_d  = '0;
      op_b_d  = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        StEnterA, StEnterB: begin
          if (key_accept) begin
            if (is_digit) begin
              if (cnt_q < MaxCnt) begin
                acc_d = acc_shift;
                cnt_d = cnt_q + CntW'(1);
              end
            end else if ((kp.dato_i == KEY_ENTER) && (cnt_q != '0)) begin
              acc_d = '0;
              cnt_d = '0;
              if (state_q == StEnterA) begin
                op_a_d  = acc_q;
                state_d = StEnterB;
              end else begin
                op_b_d  = acc_q;
                valid_d = 1'b1;
                state_d = StHold;
              end
            end
          end
        end
        StHold: begin
          // Any non-clear key accepted alongside the ack is dropped, not replayed.
          if (kp.result_ack) begin
            valid_d = 1'b0;
            state_d = StEnterA;
          end
        end
        default: state_d = StEnterA;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StEnterA;
      da_q    <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      da_q    <= kp.data_available;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      valid_q <= valid_d;
    end
  end

  assign kp.operand_a      = op_a_q;
  assign kp.operand_b      = op_b_q;
  assign kp.operands_valid = valid_q;
  assign kp.entry_value    = (state_q == StHold) ? '0 : acc_q;
  assign kp.entry_sel      = state_q;

endmodule

// File: tb/tb_keypad_operand_capture.sv
// Bench for keypad_operand_capture: directed scenarios plus random key traffic, checked
// every cycle against a digit-list model of operand entry.
module tb_keypad_operand_capture;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;

  keypad_operand_capture_if #(.OP_W(8)) kp_if ();

  keypad_operand_capture #(
    .MAX_DIGITS(2),
    .OP_W      (8),
    .KEY_ENTER (4'hA),
    .KEY_CLEAR (4'hC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kp (kp_if)
  );

  // Model: the operand being typed is a list of digits; phase 0/1/2 = A, B, holding.
  int m_digits[$];
  int m_phase;
  int m_a;
  int m_b;
  int m_valid;
  bit m_prev_da;

  function automatic int entry_of_digits();
    int v = 0;
    foreach (m_digits[i]) v = v * 10 + m_digits[i];
    return v % 256;
  endfunction

  task automatic model_reset();
    m_digits.delete();
    m_phase   = 0;
    m_a       = 0;
    m_b       = 0;
    m_valid   = 0;
    m_prev_da = 1'b0;
  endtask

  task automatic model_step(input bit da, input int code, input bit ack);
    bit accepted;
    accepted  = da && !m_prev_da;
    m_prev_da = da;
    if (accepted && code == 12) begin
      m_digits.delete();
      m_a = 0; m_b = 0; m_valid = 0; m_phase = 0;
    end else if (m_phase == 2) begin
      if (ack) begin
        m_valid = 0;
        m_phase = 0;
      end
    end else if (accepted) begin
      if (code <= 9) begin
        if (m_digits.size() < 2) m_digits.push_back(code);
      end else if (code == 10 && m_digits.size() > 0) begin
        if (m_phase == 0) begin
          m_a     = entry_of_digits();
          m_phase = 1;
        end else begin
          m_b     = entry_of_digits();
          m_valid = 1;
          m_phase = 2;
        end
        m_digits.delete();
      end
    end
  endtask

  function automatic int model_entry();
    return (m_phase == 2) ? 0 : entry_of_digits();
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("operand_a",      int'(kp_if.operand_a),      m_a);
      check("operand_b",      int'(kp_if.operand_b),      m_b);
      check("operands_valid", int'(kp_if.operands_valid), m_valid);
      check("entry_value",    int'(kp_if.entry_value),    model_entry());
      check("entry_sel",      int'(kp_if.entry_sel),      m_phase);
    end
  end

  task automatic cycle(input bit da, input logic [3:0] code, input bit ack);
    kp_if.data_available = da;
    kp_if.dato_i         = code;
    kp_if.result_ack     = ack;
    @(posedge clk);
    #1 model_step(da, int'(code), ack);
    @(negedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] code);
    repeat (10) cycle(1'b1, code, 1'b0);
    repeat (5) cycle(1'b0, 4'($urandom), 1'b0);
  endtask

  initial begin
    rst                  = 1'b0;
    kp_if.data_available = 1'b0;
    kp_if.dato_i         = 4'h0;
    kp_if.result_ack     = 1'b0;
    model_reset();
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset operand_a", int'(kp_if.operand_a), 0);
    check("reset valid",     int'(kp_if.operands_valid), 0);
    check("reset entry_sel", int'(kp_if.entry_sel), 0);
    rst = 1'b1;

    // Basic entry 12 x 34, then ack
    press(4'd1); press(4'd2); press(4'hA); press(4'd3); press(4'd4); press(4'hA);
    check("t1 operand_a", int'(kp_if.operand_a), 12);
    check("t1 operand_b", int'(kp_if.operand_b), 34);
    check("t1 valid",     int'(kp_if.operands_valid), 1);
    check("t1 entry_sel", int'(kp_if.entry_sel), 2);
    cycle(1'b0, 4'h0, 1'b1);
    check("t1 ack valid", int'(kp_if.operands_valid), 0);
    check("t1 ack sel",   int'(kp_if.entry_sel), 0);
    check("t1 ack a kept", int'(kp_if.operand_a), 12);

    // Held key counts once
    repeat (500) cycle(1'b1, 4'd7, 1'b0);
    check("t2 held entry", int'(kp_if.entry_value), 7);
    repeat (3) cycle(1'b0, 4'd7, 1'b0);

    // Digit limit and empty enter
    press(4'hC);
    press(4'd9); press(4'd8); press(4'd7); press(4'hA);
    check("t3 operand_a", int'(kp_if.operand_a), 98);
    press(4'hA);
    check("t3 empty enter sel",   int'(kp_if.entry_sel), 1);
    check("t3 empty enter valid", int'(kp_if.operands_valid), 0);

    // Clear mid-sequence
    press(4'hC);
    press(4'd5); press(4'hA); press(4'd6); press(4'hC);
    check("t4 clear sel", int'(kp_if.entry_sel), 0);
    check("t4 clear a",   int'(kp_if.operand_a), 0);
    press(4'd3); press(4'hA); press(4'd4); press(4'hA);
    check("t4 operand_a", int'(kp_if.operand_a), 3);
    check("t4 operand_b", int'(kp_if.operand_b), 4);
    check("t4 valid",     int'(kp_if.operands_valid), 1);

    // Keys in HOLD ignored; ack coincident with a digit drops the digit
    press(4'd2); press(4'hA);
    check("t5 hold a",     int'(kp_if.operand_a), 3);
    check("t5 hold b",     int'(kp_if.operand_b), 4);
    check("t5 hold entry", int'(kp_if.entry_value), 0);
    cycle(1'b1, 4'd9, 1'b1);
    check("t5 ack sel",   int'(kp_if.entry_sel), 0);
    check("t5 ack entry", int'(kp_if.entry_value), 0);
    repeat (5) cycle(1'b1, 4'd9, 1'b0);
    check("t5 no replay", int'(kp_if.entry_value), 0);
    repeat (3) cycle(1'b0, 4'd0, 1'b0);

    // Asynchronous reset mid-entry
    press(4'd4); press(4'd5);
    check("t6 pre-reset entry", int'(kp_if.entry_value), 45);
    kp_if.data_available = 1'b0;
    @(posedge clk);
    #1 model_step(1'b0, 0, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("t6 async entry", int'(kp_if.entry_value), 0);
    check("t6 async a",     int'(kp_if.operand_a), 0);
    check("t6 async b",     int'(kp_if.operand_b), 0);
    check("t6 async valid", int'(kp_if.operands_valid), 0);
    model_reset();
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    press(4'd1);
    check("t6 after reset entry", int'(kp_if.entry_value), 1);

    // Random key traffic
    for (int it = 0; it < 300; it++) begin
      int r;
      int hi;
      int lo;
      logic [3:0] code;
      r = $urandom_range(0, 9);
      if (r <= 5)      code = 4'($urandom_range(0, 9));
      else if (r <= 7) code = 4'hA;
      else if (r == 8) code = 4'hC;
      else             code = 4'($urandom_range(10, 15));
      hi = $urandom_range(1, 6);
      lo = $urandom_range(1, 4);
      for (int k = 0; k < hi; k++) cycle(1'b1, code, ($urandom_range(0, 15) == 0));
      for (int k = 0; k < lo; k++) cycle(1'b0, 4'($urandom), ($urandom_range(0, 15) == 0));
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_operand_capture.md
Name: keypad_operand_capture

Overview:
- Consumer end of the keypad decoder handshake: receives one 4-bit key code per key press (`data_available` / `dato`) and assembles decimal digits into two binary operands for the multiplier.
- Presents the operand pair with a valid/ack handshake.
- Exposes the value currently being entered for the display path.

Parameters:
- MAX_DIGITS, 2, maximum decimal digits per operand; further digits are ignored.
- OP_W, 8, operand width in bits; must hold 10^MAX_DIGITS-1.
- KEY_ENTER, 4'hA, key code that commits the current operand.
- KEY_CLEAR, 4'hC, key code that aborts entry and returns to operand A.

Ports:
- clk  input  1  system clock (27 MHz).
- rst  input  1  asynchronous, active-low reset.
- data_available  input  1  high while the decoder holds a valid key code; level, may stay high for many cycles per press.
- dato_i  input  4  key code from the decoder; valid while data_available=1.
- result_ack  input  1  multiplier has consumed the operands; one-cycle pulse.
- operand_a  output  OP_W  first operand, binary.
- operand_b  output  OP_W  second operand, binary.
- operands_valid  output  1  operand_a/operand_b are complete and stable.
- entry_value  output  OP_W  accumulator of the operand being typed (display).
- entry_sel  output  2  0 = entering A, 1 = entering B, 2 = holding valid.

Behaviour:
- Reset (rst=0, async): all outputs 0; state ENTER_A; digit count 0; da_q 0.
- Key strobe:
  - da_q is a registered copy of data_available.
  - A key is accepted on the clock edge where data_available=1 and da_q=0.
  - dato_i is sampled on that edge; effects are visible the next cycle (1-cycle latency).
  - A held key produces exactly one acceptance. Re-acceptance requires data_available to go low for at least one cycle.
- Key classes:
  - Digit: codes 0..9.
  - KEY_ENTER and KEY_CLEAR as parameterised.
  - All other codes are accepted (edge consumed) but have no effect.
- States: ENTER_A, ENTER_B, HOLD.
- Digit in ENTER_A or ENTER_B:
  - If count < MAX_DIGITS: acc <= acc*10 + digit; count++.
  - Else: ignored, acc unchanged.
  - Arithmetic is in OP_W+4 bits, truncated to OP_W. No overflow occurs with legal parameters.
- KEY_ENTER in ENTER_A:
  - If count=0: ignored.
  - Else: operand_a <= acc; acc, count <= 0; next state ENTER_B.
- KEY_ENTER in ENTER_B:
  - If count=0: ignored.
  - Else: operand_b <= acc; acc, count <= 0; operands_valid <= 1; next state HOLD.
- KEY_CLEAR in any state:
  - acc, count, operand_a, operand_b <= 0; operands_valid <= 0; next state ENTER_A.
- HOLD:
  - operand_a, operand_b and operands_valid=1 stay stable.
  - Digits and KEY_ENTER are ignored.
  - result_ack=1 clears operands_valid and moves to ENTER_A; operand_a and operand_b retain their values.
- result_ack outside HOLD: ignored.
- Simultaneous result_ack and key acceptance in HOLD:
  - KEY_CLEAR wins: clear behaviour applies, operands zeroed.
  - Otherwise the ack is taken and the key is discarded. The key is not replayed in ENTER_A.
- entry_value = acc in ENTER_A/ENTER_B; 0 in HOLD.
- Reset asserted mid-entry discards any partial operand immediately; no operands_valid pulse is produced.

Test Plan:
- Reset released; keys 1, 2, A, 3, 4, A (each data_available high 10 cycles, low 5) -> operand_a=12, operand_b=34, operands_valid=1, entry_sel=2; one cycle after result_ack: operands_valid=0, entry_sel=0.
- Hold data_available=1 with dato_i=7 for 500 cycles in ENTER_A -> entry_value=7, not 77 or larger.
- Keys 9, 8, 7, A -> third digit ignored, operand_a=98; key A with no digits in ENTER_B -> still entry_sel=1, operands_valid=0.
- Keys 5, A, 6, C, 3, A, 4, A -> clear returns to A; operand_a=3, operand_b=4, valid=1.
- In HOLD press 2 and A, then result_ack coincident with key 9 acceptance -> operands unchanged while held; after ack entry_sel=0, entry_value=0.
- Keys 4, 5 then rst=0 asynchronously mid-cycle -> entry_value, operands, operands_valid immediately 0; after release, next key 1 gives entry_value=1.
